// File: rtl/piso_shift_reg_pkg.sv
// Link-level constants shared by the serial shift-register link: state encodings and default word width.
package piso_shift_reg_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned STATE_W       = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_SHIFT = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd2;

endpackage : piso_shift_reg_pkg

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out transmitter: takes a word on a Load/Ready handshake and
// streams it one bit per clock on Sout with a Valid qualifier and a Done pulse.
module piso_shift_reg
  import piso_shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  output logic             Ready,
  output logic             Sout,
  output logic             Valid,
  output logic             Done
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   sreg_q,  sreg_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               ready_q, ready_d;
  logic               sout_q,  sout_d;
  logic               valid_q, valid_d;
  logic               done_q,  done_d;

  // Bit that leaves next, and the register after that bit has left (zero fill).
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Sout is registered, so the accepting edge already presents bit 0 and the
  // shift register keeps only the bits still to be sent.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    sout_d  = sout_q;
    valid_d = valid_q;
    done_d  = done_q;
    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        valid_d = 1'b0;
        sout_d  = 1'b0;
        done_d  = 1'b0;
        if (Load) begin
          state_d = ST_SHIFT;
          ready_d = 1'b0;
          valid_d = 1'b1;
          cnt_d   = '0;
          sout_d  = head_bit(Din);
          sreg_d  = advance(Din);
        end
      end
      ST_SHIFT: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          valid_d = 1'b0;
          sout_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          sreg_d  = '0;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          sout_d = head_bit(sreg_q);
          sreg_d = advance(sreg_q);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        sreg_d  = '0;
        cnt_d   = '0;
        ready_d = 1'b1;
        sout_d  = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign Ready = ready_q;
  assign Sout  = sout_q;
  assign Valid = valid_q;
  assign Done  = done_q;

endmodule : piso_shift_reg
